// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: walks every output window per filter, drives the conv unit and streams addressed results
module conv_window_scheduler #(
   parameter int IMG_SIZE = 32,
   parameter int K        = 5,
   parameter int STRIDE   = 1,
   parameter int CONV_LAT = 1,
   parameter int ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        num_filters,
   output logic              busy,
   output logic              done,
   output logic              win_req,
   output logic [5:0]        win_row,
   output logic [5:0]        win_col,
   output logic [3:0]        win_filter,
   input  logic              win_ack,
   output logic              conv_start,
   input  logic [15:0]       conv_result,
   output logic              out_valid,
   output logic [15:0]       out_data,
   output logic [ADDR_W-1:0] out_addr,
   input  logic              out_ready
);
   localparam int OD = (IMG_SIZE - K) / STRIDE + 1;
   typedef enum logic [2:0] {IDLE, REQ, CONV, WAIT, WRITE, DONE} state_t;
   state_t      state;
   logic [3:0]  nf;
   logic [7:0]  cnt;
   logic [31:0] addr_calc;
   logic        last_col, last_row, last_pos;
   assign last_col  = win_col == 6'(OD - 1);
   assign last_row  = win_row == 6'(OD - 1);
   assign last_pos  = last_col && last_row && (win_filter == nf - 4'd1);
   assign addr_calc = 32'(win_filter) * 32'(OD * OD) + 32'(win_row) * 32'(OD) + 32'(win_col);
   // sequencer: request window, pulse conv, wait latency, hand result to the store, advance position
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         win_req    <= 1'b0;
         conv_start <= 1'b0;
         out_valid  <= 1'b0;
         win_row    <= '0;
         win_col    <= '0;
         win_filter <= '0;
         out_data   <= '0;
         out_addr   <= '0;
         nf         <= '0;
         cnt        <= '0;
      end else begin
         done       <= 1'b0;
         conv_start <= 1'b0;
         case (state)
            IDLE: if (start) begin
               busy       <= 1'b1;
               nf         <= num_filters;
               win_row    <= '0;
               win_col    <= '0;
               win_filter <= '0;
               state      <= (num_filters == 4'd0) ? DONE : REQ;
               done       <= num_filters == 4'd0;
               win_req    <= num_filters != 4'd0;
            end
            REQ: if (win_ack) begin
               win_req    <= 1'b0;
               conv_start <= 1'b1;
               state      <= CONV;
            end
            CONV: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: if (cnt == 8'(CONV_LAT - 1)) begin
               out_data  <= conv_result;
               out_addr  <= addr_calc[ADDR_W-1:0];
               out_valid <= 1'b1;
               state     <= WRITE;
            end else begin
               cnt <= cnt + 8'd1;
            end
            WRITE: if (out_ready) begin
               out_valid  <= 1'b0;
               win_col    <= last_col ? 6'd0 : win_col + 6'd1;
               win_row    <= last_pos ? 6'd0 : last_col ? (last_row ? 6'd0 : win_row + 6'd1) : win_row;
               win_filter <= last_pos ? 4'd0 : (last_col && last_row) ? win_filter + 4'd1 : win_filter;
               state      <= last_pos ? DONE : REQ;
               done       <= last_pos;
               win_req    <= !last_pos;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_window_scheduler.sv
// tb_conv_window_scheduler: directed checks of window sequencing, handshakes, stalls and reset abort
module tb_conv_window_scheduler;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst, start, win_ack, out_ready;
   logic [3:0]  num_filters;
   logic [15:0] conv_result;
   logic        busy, done, win_req, conv_start, out_valid;
   logic [5:0]  win_row, win_col;
   logic [3:0]  win_filter;
   logic [15:0] out_data, out_addr;
   logic        start_b, win_ack_b, out_ready_b;
   logic [3:0]  num_filters_b;
   logic [15:0] conv_result_b;
   logic        busy_b, done_b, win_req_b, conv_start_b, out_valid_b;
   logic [5:0]  win_row_b, win_col_b;
   logic [3:0]  win_filter_b;
   logic [15:0] out_data_b, out_addr_b;
   conv_window_scheduler #(.IMG_SIZE(7), .K(5), .STRIDE(1), .CONV_LAT(1), .ADDR_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .num_filters(num_filters), .busy(busy), .done(done),
      .win_req(win_req), .win_row(win_row), .win_col(win_col), .win_filter(win_filter),
      .win_ack(win_ack), .conv_start(conv_start), .conv_result(conv_result),
      .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr), .out_ready(out_ready));
   conv_window_scheduler #(.IMG_SIZE(7), .K(5), .STRIDE(1), .CONV_LAT(3), .ADDR_W(16)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .num_filters(num_filters_b), .busy(busy_b), .done(done_b),
      .win_req(win_req_b), .win_row(win_row_b), .win_col(win_col_b), .win_filter(win_filter_b),
      .win_ack(win_ack_b), .conv_start(conv_start_b), .conv_result(conv_result_b),
      .out_valid(out_valid_b), .out_data(out_data_b), .out_addr(out_addr_b), .out_ready(out_ready_b));
   int checks = 0, errors = 0;
   logic [15:0] got_addr[$], got_data[$], got_pos[$];
   int done_cnt = 0, req_cnt = 0, cs_cnt = 0, done_b_cnt = 0, req_b_cnt = 0, cs_b_cnt = 0;
   // observe transfers, handshakes and pulses on both instances
   always @(posedge clk) begin
      if (out_valid && out_ready) begin
         got_addr.push_back(out_addr);
         got_data.push_back(out_data);
      end
      if (win_req && win_ack) got_pos.push_back({win_filter, win_row, win_col});
      if (done) done_cnt++;
      if (win_req) req_cnt++;
      if (conv_start) cs_cnt++;
      if (done_b) done_b_cnt++;
      if (win_req_b) req_b_cnt++;
      if (conv_start_b) cs_b_cnt++;
   end
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic go(input logic [3:0] n);
      num_filters = n;
      start = 1'b1;
      step;
      start = 1'b0;
   endtask
   task automatic wait_done(input int limit, output int n);
      n = 1;
      while (done !== 1'b1 && n < limit) begin
         step;
         n++;
      end
   endtask
   int n, base, pbase, d0, r0, c0, stall;
   logic ok;
   logic [15:0] sd, sa;
   initial begin
      rst = 1'b1; start = 1'b0; win_ack = 1'b1; out_ready = 1'b1; num_filters = 4'd0; conv_result = 16'h1234;
      start_b = 1'b0; win_ack_b = 1'b0; out_ready_b = 1'b1; num_filters_b = 4'd1; conv_result_b = 16'h5555;
      step;
      step;
      chk("rst_ctl", {busy, done, win_req, conv_start, out_valid}, 0);
      chk("rst_idx", {win_row, win_col, win_filter}, 0);
      chk("rst_out", {out_data, out_addr}, 0);
      chk("rst_b", {busy_b, done_b, win_req_b, conv_start_b, out_valid_b, win_row_b, win_col_b, win_filter_b}, 0);
      rst = 1'b0;
      step;
      // T1: one filter, handshakes tied high
      base = got_addr.size(); pbase = got_pos.size(); d0 = done_cnt;
      go(1);
      chk("t1_busy", busy, 1);
      chk("t1_req", win_req, 1);
      wait_done(200, n);
      chk("t1_cycles", n, 37);
      step;
      chk("t1_busy_drop", busy, 0);
      chk("t1_count", got_addr.size() - base, 9);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("t1_addr%0d", i), got_addr[base+i], i);
         chk($sformatf("t1_data%0d", i), got_data[base+i], 16'h1234);
         chk($sformatf("t1_pos%0d", i), got_pos[pbase+i], {4'd0, 6'(i / 3), 6'(i % 3)});
      end
      chk("t1_done", done_cnt - d0, 1);
      // T2: two filters
      base = got_addr.size(); pbase = got_pos.size(); d0 = done_cnt;
      go(2);
      wait_done(400, n);
      chk("t2_cycles", n, 73);
      step;
      chk("t2_count", got_addr.size() - base, 18);
      for (int i = 0; i < 18; i++) begin
         chk($sformatf("t2_addr%0d", i), got_addr[base+i], i);
         chk($sformatf("t2_pos%0d", i), got_pos[pbase+i], {4'(i / 9), 6'((i % 9) / 3), 6'(i % 3)});
      end
      chk("t2_done", done_cnt - d0, 1);
      // T3: store stalls five cycles on address 4
      base = got_addr.size(); pbase = got_pos.size();
      out_ready = 1'b0; stall = 0; ok = 1'b1; sd = '0; sa = '0;
      go(1);
      for (int k = 0; k < 150 && done !== 1'b1; k++) begin
         if (out_valid && out_addr == 16'd4 && stall < 5) begin
            if (stall == 0) begin
               sd = out_data;
               sa = out_addr;
            end else if (out_data !== sd || out_addr !== sa) ok = 1'b0;
            if (win_req || conv_start) ok = 1'b0;
            stall++;
            out_ready = 1'b0;
            conv_result = 16'hBEEF;
         end else begin
            out_ready = out_valid;
            conv_result = 16'h1234;
         end
         step;
      end
      chk("t3_stall_len", stall, 5);
      chk("t3_stable", ok, 1);
      chk("t3_held_data", sd, 16'h1234);
      chk("t3_done_seen", done, 1);
      step;
      chk("t3_count", got_addr.size() - base, 9);
      chk("t3_addr4", got_addr[base+4], 4);
      chk("t3_resume", got_pos[pbase+5], {4'd0, 6'd1, 6'd2});
      out_ready = 1'b1;
      conv_result = 16'h1234;
      // T4: delayed ack and CONV_LAT=3 on second instance
      r0 = req_b_cnt; c0 = cs_b_cnt; d0 = done_b_cnt;
      start_b = 1'b1;
      step;
      start_b = 1'b0;
      chk("t4_req_c1", win_req_b, 1);
      step;
      step;
      step;
      chk("t4_req_c4", win_req_b, 1);
      chk("t4_no_cs_early", conv_start_b, 0);
      win_ack_b = 1'b1;
      step;
      chk("t4_cs", conv_start_b, 1);
      chk("t4_req_drop", win_req_b, 0);
      step;
      step;
      step;
      chk("t4_cs_once", cs_b_cnt - c0, 1);
      chk("t4_req_cycles", req_b_cnt - r0, 4);
      chk("t4_not_yet_valid", out_valid_b, 0);
      conv_result_b = 16'h0A00;
      step;
      conv_result_b = 16'h5555;
      chk("t4_valid", out_valid_b, 1);
      chk("t4_data", out_data_b, 16'h0A00);
      chk("t4_addr", out_addr_b, 0);
      for (int k = 0; k < 200 && done_b !== 1'b1; k++) step;
      chk("t4_done_seen", done_b, 1);
      step;
      chk("t4_busy_drop", busy_b, 0);
      chk("t4_cs_total", cs_b_cnt - c0, 9);
      chk("t4_done_once", done_b_cnt - d0, 1);
      // T5: zero filters
      r0 = req_cnt; d0 = done_cnt;
      go(0);
      chk("t5_busy", busy, 1);
      chk("t5_done", done, 1);
      chk("t5_no_req", win_req, 0);
      step;
      chk("t5_busy_drop", busy, 0);
      chk("t5_done_drop", done, 0);
      chk("t5_req_cnt", req_cnt - r0, 0);
      chk("t5_done_cnt", done_cnt - d0, 1);
      // T6: reset in WAIT of the third result, then clean restart
      go(1);
      for (int k = 0; k < 10; k++) step;
      chk("t6_progress", out_addr, 1);
      rst = 1'b1;
      step;
      chk("t6_rst_ctl", {busy, done, win_req, conv_start, out_valid}, 0);
      chk("t6_rst_idx", {win_row, win_col, win_filter}, 0);
      chk("t6_rst_out", {out_data, out_addr}, 0);
      rst = 1'b0;
      r0 = req_cnt; d0 = done_cnt;
      step;
      step;
      step;
      chk("t6_quiet_req", req_cnt - r0, 0);
      chk("t6_quiet_done", done_cnt - d0, 0);
      base = got_addr.size(); pbase = got_pos.size(); d0 = done_cnt;
      go(1);
      chk("t6_restart", {win_req, win_filter, win_row, win_col}, 17'h10000);
      for (int k = 0; k < 200 && done !== 1'b1; k++) begin
         start = (k % 3 == 0);
         num_filters = 4'd3;
         step;
      end
      start = 1'b0;
      chk("t6_done_seen", done, 1);
      step;
      chk("t6_count", got_addr.size() - base, 9);
      chk("t6_first_pos", got_pos[pbase], 0);
      chk("t6_last_addr", got_addr[base+8], 8);
      chk("t6_done_once", done_cnt - d0, 1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
